// File: rtl/solo_squash_inputs.sv
// Button conditioner for the squash core: 2-FF sync, tick-sampled debounce,
// pause toggle, one-shot new-game pulse and up+down contradiction masking.

module solo_squash_debounce #(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic press
);
  localparam logic [3:0] LAST = 4'(STABLE_TICKS - 1);

  logic [1:0] sync;
  logic [3:0] cnt;
  logic       level_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= 2'b11;
      level      <= 1'b1;
      level_prev <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      sync       <= {sync[0], raw};
      level_prev <= level;
      // a differing sample must persist for STABLE_TICKS consecutive ticks
      if (tick) begin
        if (sync[1] == level) begin
          cnt <= 4'd0;
        end else if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign press = level_prev & ~level;
endmodule

module solo_squash_inputs #(
  parameter int TICK_DIV     = 250000,
  parameter int STABLE_TICKS = 3,
  parameter int PAUSE_TOGGLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause_n,
  input  logic btn_new_game_n,
  input  logic btn_down_n,
  input  logic btn_up_n,
  output logic pause_n,
  output logic new_game_n,
  output logic down_key_n,
  output logic up_key_n,
  output logic tick
);
  localparam int NUM_BTN = 4;
  localparam int B_PAUSE = 0;
  localparam int B_NEW   = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int CW      = $clog2(TICK_DIV);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [CW-1:0]      pre;
  logic               paused;
  logic               paused_nxt;

  assign raw = {btn_up_n, btn_down_n, btn_new_game_n, btn_pause_n};

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      solo_squash_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw[i]),
        .tick  (tick),
        .level (level[i]),
        .press (press[i])
      );
    end
  endgenerate

  // new game dominates a simultaneous pause press
  always_comb begin
    paused_nxt = paused;
    if (press[B_NEW])        paused_nxt = 1'b0;
    else if (press[B_PAUSE]) paused_nxt = ~paused;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      tick       <= 1'b0;
      paused     <= 1'b0;
      pause_n    <= 1'b1;
      new_game_n <= 1'b1;
      down_key_n <= 1'b1;
      up_key_n   <= 1'b1;
    end else begin
      tick <= (pre == CW'(TICK_DIV - 1));
      pre  <= (pre == CW'(TICK_DIV - 1)) ? '0 : pre + 1'b1;

      paused     <= paused_nxt;
      pause_n    <= (PAUSE_TOGGLE != 0) ? ~paused_nxt : level[B_PAUSE];
      new_game_n <= ~press[B_NEW];

      if (!level[B_UP] && !level[B_DOWN]) begin
        down_key_n <= 1'b1;
        up_key_n   <= 1'b1;
      end else begin
        down_key_n <= level[B_DOWN];
        up_key_n   <= level[B_UP];
      end
    end
  end
endmodule

// File: tb/tb_solo_squash_inputs.sv
// Directed bench for solo_squash_inputs with TICK_DIV=4, STABLE_TICKS=3.

module tb_solo_squash_inputs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] btn = 4'hF;  // 0 pause, 1 new game, 2 down, 3 up
  logic pause_n, new_game_n, down_key_n, up_key_n, tick;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  solo_squash_inputs #(.TICK_DIV(4), .STABLE_TICKS(3), .PAUSE_TOGGLE(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_pause_n    (btn[0]),
    .btn_new_game_n (btn[1]),
    .btn_down_n     (btn[2]),
    .btn_up_n       (btn[3]),
    .pause_n        (pause_n),
    .new_game_n     (new_game_n),
    .down_key_n     (down_key_n),
    .up_key_n       (up_key_n),
    .tick           (tick)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn   = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ends on the negedge where the n-th tick strobe is visible
  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 100) begin
      if (tick) seen++;
      if (seen < n) @(negedge clk);
      guard++;
    end
    checks++;
    if (seen < n) begin
      failures++;
      $display("FAIL wait_ticks: saw %0d ticks, need %0d", seen, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    btn   = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pause_n, new_game_n, down_key_n, up_key_n, tick} !== 5'b11110) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 11110",
               {pause_n, new_game_n, down_key_n, up_key_n, tick});
    end
    btn   = 4'hF;
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (tick !== (k % 4 == 0)) begin
        failures++;
        $display("FAIL tick_phase cycle %0d: got %b want %b", k, tick, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_down();
    do_reset();
    btn[2] = 1'b0;
    repeat (2) @(negedge clk);
    wait_ticks(3);
    checks++;
    if (down_key_n !== 1'b1) begin failures++; $display("FAIL down_early: got %b want 1", down_key_n); end
    @(negedge clk);
    checks++;
    if (down_key_n !== 1'b1) begin failures++; $display("FAIL down_latency: got %b want 1", down_key_n); end
    @(negedge clk);
    checks++;
    if ({down_key_n, up_key_n} !== 2'b01) begin
      failures++; $display("FAIL down_press: got %b want 01", {down_key_n, up_key_n});
    end
    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    wait_ticks(3);
    @(negedge clk);
    checks++;
    if (down_key_n !== 1'b0) begin failures++; $display("FAIL down_hold: got %b want 0", down_key_n); end
    @(negedge clk);
    checks++;
    if (down_key_n !== 1'b1) begin failures++; $display("FAIL down_release: got %b want 1", down_key_n); end
  endtask

  task automatic test_bounce();
    logic bad = 1'b0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      btn[3] = 1'b0;
      repeat (2) @(negedge clk);
      if (up_key_n !== 1'b1) bad = 1'b1;
      wait_ticks(2);
      btn[3] = 1'b1;
      if (up_key_n !== 1'b1) bad = 1'b1;
      wait_ticks(2);
      if (up_key_n !== 1'b1) bad = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (up_key_n !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL bounce_reject: up_key_n went 0, want 1 throughout"); end
  endtask

  task automatic test_new_game();
    int pulses = 0;
    do_reset();
    btn[0] = 1'b0;
    repeat (30) @(negedge clk);
    btn[0] = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (pause_n !== 1'b0) begin failures++; $display("FAIL ng_paused: got %b want 0", pause_n); end
    btn[1] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (new_game_n === 1'b0) pulses++;
    end
    btn[1] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (new_game_n === 1'b0) pulses++;
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL ng_pulse_count: got %0d want 1", pulses); end
    checks++;
    if (pause_n !== 1'b1) begin failures++; $display("FAIL ng_unpause: got %b want 1", pause_n); end
  endtask

  task automatic test_pause();
    logic [3:0] seen;
    logic       paused_seen = 1'b0;
    int         pulses = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      btn[0] = 1'b0;
      repeat (30) @(negedge clk);
      seen[2*r] = pause_n;
      btn[0] = 1'b1;
      repeat (30) @(negedge clk);
      seen[2*r+1] = pause_n;
    end
    checks++;
    if (seen !== 4'b1100) begin
      failures++; $display("FAIL pause_toggle: got %b want 1100 (press,rel,press,rel lsb first)", seen);
    end
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (new_game_n === 1'b0) pulses++;
      if (pause_n !== 1'b1) paused_seen = 1'b1;
    end
    btn = 4'hF;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL same_cycle_pulse: got %0d want 1", pulses); end
    checks++;
    if (paused_seen || pause_n !== 1'b1) begin
      failures++; $display("FAIL same_cycle_pause: got paused_seen=%b pause_n=%b want 0/1", paused_seen, pause_n);
    end
  endtask

  task automatic test_both();
    logic moved = 1'b0;
    do_reset();
    btn[2] = 1'b0;
    btn[3] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (down_key_n !== 1'b1 || up_key_n !== 1'b1) moved = 1'b1;
    end
    checks++;
    if (moved) begin failures++; $display("FAIL both_masked: an output went 0, want both 1"); end
    btn[2] = 1'b1;
    repeat (2) @(negedge clk);
    wait_ticks(3);
    @(negedge clk);
    checks++;
    if (up_key_n !== 1'b1) begin failures++; $display("FAIL up_latency: got %b want 1", up_key_n); end
    @(negedge clk);
    checks++;
    if ({down_key_n, up_key_n} !== 2'b10) begin
      failures++; $display("FAIL up_after_down_rel: got %b want 10", {down_key_n, up_key_n});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pause_n, new_game_n, down_key_n, up_key_n, tick} !== 5'b11110) begin
      failures++; $display("FAIL reset_mid_press: got %b want 11110",
                           {pause_n, new_game_n, down_key_n, up_key_n, tick});
    end
    btn = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down();
    test_bounce();
    test_new_game();
    test_pause();
    test_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
